// File: rtl/alu_regfile_if.sv
// Bus bundle between the CPU sequencer (master) and the alu_regfile datapath slice (slave).
// Flag outputs exist only when ALU_FLAGS_EN is defined.
interface alu_regfile_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 1
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] rsel;
    logic [WIDTH-1:0]  rdata;
    logic [WIDTH-1:0]  operand_A;
    logic [WIDTH-1:0]  operand_B;
    logic [2:0]        alu_control;
    logic [WIDTH-1:0]  result;
`ifdef ALU_FLAGS_EN
    logic              zero;
    logic              carry;
    logic              negative;
    logic              overflow;
`endif

`ifdef ALU_FLAGS_EN
    modport master (
        output we, waddr, wdata, rsel, operand_A, operand_B, alu_control,
        input  rdata, result, zero, carry, negative, overflow
    );
    modport slave (
        input  we, waddr, wdata, rsel, operand_A, operand_B, alu_control,
        output rdata, result, zero, carry, negative, overflow
    );
`else
    modport master (
        output we, waddr, wdata, rsel, operand_A, operand_B, alu_control,
        input  rdata, result
    );
    modport slave (
        input  we, waddr, wdata, rsel, operand_A, operand_B, alu_control,
        output rdata, result
    );
`endif
endinterface

// File: rtl/alu_regfile.sv
// Datapath slice: 2**ADDR_W-entry register file (async clear, combinational read) beside a
// combinational ALU. Optional flag outputs are enabled by defining ALU_FLAGS_EN.
module alu_regfile #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_regfile_if.slave  bus
);
    localparam int NREGS = 1 << ADDR_W;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    // Register file storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {WIDTH{1'b0}};
            end
        end else if (bus.we) begin
            r_regs[bus.waddr] <= bus.wdata;
        end else begin
            r_regs[bus.waddr] <= r_regs[bus.waddr];
        end
    end

    // No write bypass: a same-cycle write becomes visible only after the edge.
    assign bus.rdata = r_regs[bus.rsel];

    assign w_sum  = bus.operand_A + bus.operand_B;
    assign w_diff = bus.operand_A - bus.operand_B;

    // ALU operation decode.
    always_comb begin
        w_result = bus.operand_A;
        case (bus.alu_control)
            OP_LOAD: w_result = bus.operand_B;
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_diff;
            OP_AND:  w_result = bus.operand_A & bus.operand_B;
            OP_OR:   w_result = bus.operand_A | bus.operand_B;
            OP_XOR:  w_result = bus.operand_A ^ bus.operand_B;
            OP_JMP:  w_result = bus.operand_A;
            OP_HLT:  w_result = bus.operand_A;
            default: w_result = bus.operand_A;
        endcase
    end

    assign bus.result = w_result;

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_add_ext;
    logic [WIDTH:0] w_sub_ext;
    logic           w_carry;
    logic           w_overflow;

    assign w_add_ext = {1'b0, bus.operand_A} + {1'b0, bus.operand_B};
    assign w_sub_ext = {1'b0, bus.operand_A} - {1'b0, bus.operand_B};

    // Carry/borrow and signed overflow only mean something for ADD and SUB.
    always_comb begin
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        if (bus.alu_control == OP_ADD) begin
            w_carry    = w_add_ext[WIDTH];
            w_overflow = (bus.operand_A[WIDTH-1] == bus.operand_B[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != bus.operand_A[WIDTH-1]);
        end else if (bus.alu_control == OP_SUB) begin
            w_carry    = w_sub_ext[WIDTH];
            w_overflow = (bus.operand_A[WIDTH-1] != bus.operand_B[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != bus.operand_A[WIDTH-1]);
        end else begin
            w_carry    = 1'b0;
            w_overflow = 1'b0;
        end
    end

    assign bus.zero     = (w_result == {WIDTH{1'b0}});
    assign bus.carry    = w_carry;
    assign bus.negative = w_result[WIDTH-1];
    assign bus.overflow = w_overflow;
`endif

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed test-plan steps, then random traffic
// checked against an arithmetic reference model.
module tb_alu_regfile;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [7:0] m_regs [2];

    alu_regfile_if #(.WIDTH(8), .ADDR_W(1)) bus ();

    alu_regfile #(.WIDTH(8), .ADDR_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
        case (op)
            0:       return 8'(b);
            1:       return 8'((a + b) % 256);
            2:       return 8'((a - b + 256) % 256);
            3:       return 8'(a & b);
            4:       return 8'(a | b);
            5:       return 8'(a ^ b);
            default: return 8'(a);
        endcase
    endfunction

    function automatic int sgn(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic alu_chk(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        int r;
        bus.operand_A   = a;
        bus.operand_B   = b;
        bus.alu_control = op;
        #1;
        chk(tag, bus.result, ref_alu(int'(a), int'(b), int'(op)));
`ifdef ALU_FLAGS_EN
        r = int'(ref_alu(int'(a), int'(b), int'(op)));
        chk({tag, "_z"}, {7'd0, bus.zero}, {7'd0, r == 0});
        chk({tag, "_n"}, {7'd0, bus.negative}, {7'd0, r > 127});
        if (op == 3'd1) begin
            chk({tag, "_c"}, {7'd0, bus.carry}, {7'd0, (int'(a) + int'(b)) > 255});
            chk({tag, "_v"}, {7'd0, bus.overflow},
                {7'd0, ((sgn(int'(a)) + sgn(int'(b))) > 127) || ((sgn(int'(a)) + sgn(int'(b))) < -128)});
        end else if (op == 3'd2) begin
            chk({tag, "_c"}, {7'd0, bus.carry}, {7'd0, int'(a) < int'(b)});
            chk({tag, "_v"}, {7'd0, bus.overflow},
                {7'd0, ((sgn(int'(a)) - sgn(int'(b))) > 127) || ((sgn(int'(a)) - sgn(int'(b))) < -128)});
        end else begin
            chk({tag, "_c"}, {7'd0, bus.carry}, 8'd0);
            chk({tag, "_v"}, {7'd0, bus.overflow}, 8'd0);
        end
`else
        r = 0;
`endif
    endtask

    task automatic write_reg(input logic [0:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        m_regs[addr] = data;
    endtask

    task automatic read_chk(input string tag, input logic [0:0] sel, input logic [7:0] exp);
        bus.rsel = sel;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_regs[0] = 8'h00;
        m_regs[1] = 8'h00;
        bus.we = 1'b0; bus.waddr = 1'b0; bus.wdata = 8'h00; bus.rsel = 1'b0;
        bus.operand_A = 8'h00; bus.operand_B = 8'h00; bus.alu_control = 3'd0;
        reset = 1'b0;
        #12;
        read_chk("rst_init_r0", 1'b0, 8'h00);
        read_chk("rst_init_r1", 1'b1, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Reset test: preload, assert mid-cycle, write attempt during reset.
        write_reg(1'b0, 8'hAA);
        write_reg(1'b1, 8'h55);
        read_chk("pre_rst_r0", 1'b0, 8'hAA);
        read_chk("pre_rst_r1", 1'b1, 8'h55);
        @(negedge clk);
        #2;
        reset = 1'b0;
        m_regs[0] = 8'h00;
        m_regs[1] = 8'h00;
        read_chk("in_rst_r0", 1'b0, 8'h00);
        read_chk("in_rst_r1", 1'b1, 8'h00);
        bus.we = 1'b1; bus.waddr = 1'b1; bus.wdata = 8'hFF;
        @(posedge clk);
        #1;
        read_chk("rst_wr_r1", 1'b1, 8'h00);
        @(negedge clk);
        bus.we = 1'b0;
        reset  = 1'b1;
        read_chk("post_rst_r0", 1'b0, 8'h00);
        read_chk("post_rst_r1", 1'b1, 8'h00);

        // Write/read and write-disable.
        write_reg(1'b1, 8'h3C);
        read_chk("wr_r1", 1'b1, 8'h3C);
        read_chk("wr_r0", 1'b0, 8'h00);
        @(negedge clk);
        bus.we = 1'b0; bus.waddr = 1'b1; bus.wdata = 8'hFF;
        @(posedge clk);
        #1;
        read_chk("we0_r1", 1'b1, 8'h3C);

        // Collision: old value before the edge, new one after.
        @(negedge clk);
        bus.rsel = 1'b0; bus.we = 1'b1; bus.waddr = 1'b0; bus.wdata = 8'h7E;
        #1;
        chk("coll_before", bus.rdata, 8'h00);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        m_regs[0] = 8'h7E;
        chk("coll_after", bus.rdata, 8'h7E);

        // ALU directed vectors.
        alu_chk("add_wrap", 8'hF0, 8'h20, 3'd1);
        chk("add_wrap_val", bus.result, 8'h10);
        alu_chk("sub_neg", 8'h05, 8'h07, 3'd2);
        chk("sub_neg_val", bus.result, 8'hFE);
        alu_chk("load", 8'h33, 8'h09, 3'd0);
        chk("load_val", bus.result, 8'h09);
        alu_chk("and", 8'hCC, 8'hAA, 3'd3);
        chk("and_val", bus.result, 8'h88);
        alu_chk("or", 8'hCC, 8'hAA, 3'd4);
        chk("or_val", bus.result, 8'hEE);
        alu_chk("xor", 8'hCC, 8'hAA, 3'd5);
        chk("xor_val", bus.result, 8'h66);
        alu_chk("jmp", 8'hCC, 8'hAA, 3'd6);
        chk("jmp_val", bus.result, 8'hCC);
        alu_chk("hlt", 8'hCC, 8'hAA, 3'd7);
        chk("hlt_val", bus.result, 8'hCC);
`ifdef ALU_FLAGS_EN
        alu_chk("flag_add_ovf", 8'h7F, 8'h01, 3'd1);
        chk("fa_res", bus.result, 8'h80);
        chk("fa_v", {7'd0, bus.overflow}, 8'd1);
        chk("fa_n", {7'd0, bus.negative}, 8'd1);
        chk("fa_c", {7'd0, bus.carry}, 8'd0);
        chk("fa_z", {7'd0, bus.zero}, 8'd0);
        alu_chk("flag_sub_zero", 8'h03, 8'h03, 3'd2);
        chk("fs_z", {7'd0, bus.zero}, 8'd1);
        chk("fs_c", {7'd0, bus.carry}, 8'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            logic       rw;
            logic [0:0] wa;
            logic [0:0] rs;
            logic [7:0] wd;
            @(negedge clk);
            rw = 1'($urandom_range(0, 1));
            wa = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            wd = 8'($urandom_range(0, 255));
            bus.we = rw; bus.waddr = wa; bus.wdata = wd; bus.rsel = rs;
            alu_chk("rnd_alu", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    3'($urandom_range(0, 7)));
            chk("rnd_rd_pre", bus.rdata, m_regs[rs]);
            @(posedge clk);
            #1;
            if (rw) m_regs[wa] = wd;
            chk("rnd_rd_post", bus.rdata, m_regs[rs]);
        end
        bus.we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Execution datapath slice for the 8-bit accumulator CPU. Combines a small register file with a combinational 8-bit ALU.
- The CPU control unit drives both halves. The register file holds general-purpose operands; the ALU computes ADD/SUB/AND/OR/XOR results for the accumulator.
- The two halves share no internal path. The CPU sequencer does all routing.

Parameters:
- WIDTH, 8, data width of registers, ALU operands and result.
- ADDR_W, 1, register address width; the file holds 2**ADDR_W registers (default 2).

Ports:
- clk  input  1  single system clock; the register file samples on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- we  input  1  register-file write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- rsel  input  ADDR_W  read select.
- rdata  output  WIDTH  read data, combinational from the selected register.
- operand_A  input  WIDTH  ALU operand A (accumulator).
- operand_B  input  WIDTH  ALU operand B (immediate or register).
- alu_control  input  3  ALU operation select.
- result  output  WIDTH  ALU result, combinational.

Behaviour:
- Reset: when reset=0, all registers clear to 0 immediately, regardless of clk.
  - rdata reads 0 while reset is held.
  - Writes are ignored while reset=0.
  - Deassertion is synchronized by the CPU; this block only needs async assert.
- Write: on a rising clk with reset=1 and we=1, regs[waddr] <= wdata.
  - With we=0, no register changes.
  - All registers are writable; none is hardwired.
- Read: rdata = regs[rsel], combinational, zero cycles latency.
- Write/read collision (same address, same cycle): no bypass. rdata shows the old value until the clock edge, then the new value.
- Reset mid-operation: a pending write in the same cycle as reset assertion is lost; the register reads 0.
- ALU: purely combinational, no clock or reset dependence. Results are modulo 2**WIDTH (carry and borrow discarded).
  - 000 LOAD: result = operand_B.
  - 001 ADD: A + B.
  - 010 SUB: A - B (two's complement wrap).
  - 011 AND: A & B.
  - 100 OR: A | B.
  - 101 XOR: A ^ B.
  - 110 JMP and 111 HLT: result = operand_A (pass-through, no side effect).
- No X propagation for defined inputs. Every alu_control value yields a defined result.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, four extra outputs are added, all combinational from the current ALU inputs:
  - zero: result == 0.
  - carry: carry-out for ADD; borrow (A < B unsigned) for SUB; 0 otherwise.
  - negative: result[WIDTH-1].
  - overflow: signed overflow for ADD/SUB; 0 otherwise.
- When not defined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: reset=0 with registers previously written 8'hAA / 8'h55, then release. Required: rdata=0 for rsel=0 and rsel=1 both during and after reset; a clk edge with we=1 during reset leaves registers at 0.
- Write/read: we=1, waddr=1, wdata=8'h3C, one clk edge, then rsel=1 -> rdata=8'h3C; rsel=0 -> rdata=0. With we=0, wdata=8'hFF and an edge -> register 1 still reads 8'h3C.
- Collision: rsel=0, we=1, waddr=0, wdata=8'h7E. Before the edge rdata=old value 8'h00; after the edge rdata=8'h7E.
- ALU arithmetic:
  - ADD A=8'hF0, B=8'h20 -> 8'h10 (wrap).
  - SUB A=8'h05, B=8'h07 -> 8'hFE.
  - LOAD B=8'h09 -> 8'h09.
- ALU logic: A=8'hCC, B=8'hAA.
  - AND -> 8'h88; OR -> 8'hEE; XOR -> 8'h66.
  - alu_control 110 and 111 -> 8'hCC.
- Flags (ALU_FLAGS_EN): ADD 8'h7F + 8'h01 -> result 8'h80, overflow=1, negative=1, carry=0, zero=0. SUB 8'h03 - 8'h03 -> zero=1, carry=0.
